// File: rtl/pac_pkg.sv
// rtl/pac_pkg.sv - shared direction codes, tile size and FSM encoding for the Pac-Man mover
package pac_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam int TILE = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PROBE_Q = 3'd1,
      ST_CHECK_Q = 3'd2,
      ST_PROBE_C = 3'd3,
      ST_CHECK_C = 3'd4
   } state_t;

endpackage

// File: rtl/pac_step.sv
// rtl/pac_step.sv - one-tile step of a position in a direction, with out-of-bounds detection
module pac_step #(
   parameter logic [9:0] MAX_X = 10'd624,
   parameter logic [8:0] MAX_Y = 9'd464
) (
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [1:0] dir,
   output logic [9:0] step_x,
   output logic [8:0] step_y,
   output logic       oob
);
   import pac_pkg::*;

   localparam logic [10:0] TILE_X = 11'(TILE);
   localparam logic [9:0]  TILE_Y = 10'(TILE);

   logic [10:0] wide_x;
   logic [9:0]  wide_y;

   // Step one bit wider than the port so the bounds test sees the real result before truncation
   always_comb begin
      wide_x = {1'b0, x};
      wide_y = {1'b0, y};
      oob    = 1'b0;
      case (dir)
         DIR_UP: begin
            oob    = (wide_y < TILE_Y);
            wide_y = wide_y - TILE_Y;
         end
         DIR_DOWN: begin
            wide_y = wide_y + TILE_Y;
            oob    = (wide_y > {1'b0, MAX_Y});
         end
         DIR_LEFT: begin
            oob    = (wide_x < TILE_X);
            wide_x = wide_x - TILE_X;
         end
         default: begin
            wide_x = wide_x + TILE_X;
            oob    = (wide_x > {1'b0, MAX_X});
         end
      endcase
   end

   assign step_x = wide_x[9:0];
   assign step_y = wide_y[8:0];

endmodule

// File: rtl/pac_mover.sv
// rtl/pac_mover.sv - tile mover: tries the queued turn, falls back to straight ahead, else blocked
module pac_mover #(
   parameter logic [9:0] START_X = 10'd304,
   parameter logic [8:0] START_Y = 9'd368,
   parameter logic [9:0] MAX_X   = 10'd624,
   parameter logic [8:0] MAX_Y   = 9'd464
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dir_req_valid,
   input  logic [1:0] dir_req,
   input  logic       tick,
   output logic [9:0] probe_x,
   output logic [8:0] probe_y,
   input  logic       is_wall,
   output logic [9:0] pac_x,
   output logic [8:0] pac_y,
   output logic [1:0] pac_dir,
   output logic       moved,
   output logic       blocked
);
   import pac_pkg::*;

   state_t     state;
   state_t     state_nx;
   logic [1:0] qdir;

   // Candidate captured during a PROBE state and committed by the following CHECK state
   logic [9:0] held_x;
   logic [8:0] held_y;
   logic       held_oob;
   logic [1:0] held_dir;

   logic [1:0] step_dir;
   logic [9:0] step_x;
   logic [8:0] step_y;
   logic       step_oob;
   logic       step_free;
   logic       in_probe;
   logic       commit;
   logic       dead_end;

   assign step_dir  = (state == ST_PROBE_Q) ? qdir : pac_dir;
   assign step_free = !is_wall && !held_oob;

   pac_step #(
      .MAX_X(MAX_X),
      .MAX_Y(MAX_Y)
   ) u_step (
      .x     (pac_x),
      .y     (pac_y),
      .dir   (step_dir),
      .step_x(step_x),
      .step_y(step_y),
      .oob   (step_oob)
   );

   // The probe address is live in a PROBE state so the map answers during the CHECK state after it
   assign probe_x = in_probe ? step_x : held_x;
   assign probe_y = in_probe ? step_y : held_y;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; ticks outside IDLE are dropped
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (tick) state_nx = ST_PROBE_Q;
         ST_PROBE_Q: state_nx = ST_CHECK_Q;
         ST_CHECK_Q: state_nx = step_free ? ST_IDLE : ST_PROBE_C;
         ST_PROBE_C: state_nx = ST_CHECK_C;
         ST_CHECK_C: state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Output decode: when to sample the stepper and when a check commits or gives up
   always_comb begin
      in_probe = 1'b0;
      commit   = 1'b0;
      dead_end = 1'b0;
      case (state)
         ST_PROBE_Q: in_probe = 1'b1;
         ST_PROBE_C: in_probe = 1'b1;
         ST_CHECK_Q: commit   = step_free;
         ST_CHECK_C: begin
            commit   = step_free;
            dead_end = !step_free;
         end
         default: ;
      endcase
   end

   // Latest keyboard request wins, whatever the FSM is doing
   always_ff @(posedge clk) begin
      if (rst)                qdir <= DIR_LEFT;
      else if (dir_req_valid) qdir <= dir_req;
   end

   // Capture the probed candidate so a late request cannot change what gets committed
   always_ff @(posedge clk) begin
      if (rst) begin
         held_x   <= START_X;
         held_y   <= START_Y;
         held_oob <= 1'b0;
         held_dir <= DIR_LEFT;
      end else if (in_probe) begin
         held_x   <= step_x;
         held_y   <= step_y;
         held_oob <= step_oob;
         held_dir <= step_dir;
      end
   end

   // Position, direction and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         pac_x   <= START_X;
         pac_y   <= START_Y;
         pac_dir <= DIR_LEFT;
         moved   <= 1'b0;
         blocked <= 1'b0;
      end else begin
         moved <= commit;
         if (commit) begin
            pac_x   <= held_x;
            pac_y   <= held_y;
            pac_dir <= held_dir;
            blocked <= 1'b0;
         end else if (dead_end) begin
            blocked <= 1'b1;
         end
      end
   end

endmodule

// File: doc/pac_mover.md
PAC_MOVER -- requirements
Module: pac_mover

Interface
REQ-001 Parameter: START_X, 10'd304, Pac-Man x position after reset, in pixels, 16-aligned.
REQ-002 Parameter: START_Y, 9'd368, Pac-Man y position after reset, in pixels, 16-aligned.
REQ-003 Parameter: MAX_X, 10'd624, largest legal tile-origin x.
REQ-004 Parameter: MAX_Y, 9'd464, largest legal tile-origin y.
REQ-005 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset; synchronous and active-high.
REQ-007 Port: dir_req_valid  input  1  one-cycle strobe; a new direction request from the keyboard.
REQ-008 Port: dir_req  input  2  requested direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 Port: tick  input  1  one-cycle move strobe from the game timer.
REQ-010 Port: probe_x  output  10  x of the tile being queried in the wall map.
REQ-011 Port: probe_y  output  9  y of the tile being queried in the wall map.
REQ-012 Port: is_wall  input  1  wall-map answer; valid exactly one cycle after probe_x/probe_y are presented.
REQ-013 Port: pac_x  output  10  current Pac-Man x.
REQ-014 Port: pac_y  output  9  current Pac-Man y.
REQ-015 Port: pac_dir  output  2  current travel direction (same encoding as dir_req).
REQ-016 Port: moved  output  1  one-cycle pulse when pac_x/pac_y change.
REQ-017 Port: blocked  output  1  level; high while the last move attempt failed in both directions.

Function
REQ-018 The block SHALL latch dir_req into a queued-direction register (qdir) on every dir_req_valid, in any FSM state; the latest request wins.
REQ-019 The FSM SHALL have states IDLE, PROBE_Q, CHECK_Q, PROBE_C, CHECK_C.
REQ-020 In IDLE, tick SHALL move to PROBE_Q; ticks arriving outside IDLE SHALL be ignored, not queued.
REQ-021 PROBE_Q SHALL drive probe_x/probe_y = position stepped 16 px in qdir, then go to CHECK_Q.
REQ-022 CHECK_Q: if is_wall=0 and the step is in bounds, the block SHALL set pac_dir<=qdir, update the position, pulse moved, clear blocked, and return to IDLE; otherwise it SHALL go to PROBE_C.
REQ-023 PROBE_C SHALL probe the position stepped in pac_dir; CHECK_C SHALL move as in REQ-022 (pac_dir unchanged) if free, else set blocked=1, leave the position unchanged, and return to IDLE.
REQ-024 qdir SHALL be retained after a failed turn so that the turn is retried on each later tick.
REQ-025 Step arithmetic: up y-16, down y+16, left x-16, right x+16; a step below 0 or above MAX_X/MAX_Y SHALL be treated as a wall without wrap-around, and the bounds check SHALL be computed before truncation to the port width.
REQ-026 Tick-to-moved latency SHALL be 3 cycles on the qdir path and 5 cycles on the fallback path.
REQ-027 When not in a PROBE state, probe_x/probe_y SHALL hold their last value.
REQ-028 If dir_req_valid and tick coincide in IDLE, the new request SHALL be used for the PROBE_Q that follows.

Reset
REQ-029 On rst: state=IDLE, pac_x=START_X, pac_y=START_Y, pac_dir=2'b10, qdir=2'b10, probe_x=START_X, probe_y=START_Y, moved=0, blocked=0.
REQ-030 rst SHALL take priority over all inputs, including when asserted mid-probe; no move SHALL be committed in the reset cycle.

Structure
REQ-031 Shared package pac_pkg SHALL hold the direction codes (DIR_UP/DOWN/LEFT/RIGHT), TILE=16, and the FSM state encoding.
REQ-032 One combinational sub-module, pac_step, SHALL compute the stepped coordinates and the out-of-bounds flag from (x, y, dir); it SHALL be instantiated once and shared by the PROBE states.

Verification
REQ-033 Free path: reset, dir_req=11, tick, map all-free -> moved high on cycle 3; pac_x=320, pac_y=368, pac_dir=11.
REQ-034 Blocked turn, free straight: pac_dir=10, qdir=00 with a wall at (304,352), tick -> pac_x=288, pac_dir=10, qdir still 00, moved on cycle 5.
REQ-035 Dead end: walls on both the qdir and pac_dir steps -> position unchanged, blocked=1, no moved pulse.
REQ-036 Edge: position (0,y), dir left, map free -> treated as wall, blocked=1, pac_x stays 0; same check at x=624 moving right.
REQ-037 Reset mid-operation: rst asserted in CHECK_Q with is_wall=0 -> position returns to (START_X,START_Y), moved=0.
REQ-038 Tick while busy: second tick in PROBE_C -> exactly one move per completed sequence, and moved pulses once.
